// File: rtl/rf_wb_arbiter.sv
// Register-file write port arbiter: buffers load returns in a small FIFO, grants loads first,
// and forces an execute grant after MAX_WAIT consecutive stalled execute cycles.
module rf_wb_arbiter #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned LQ_DEPTH = 2,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic                              CLK,
  input  logic                              reset,
  input  logic                              ex_valid,
  input  logic [ADDR_W-1:0]                 ex_rd,
  input  logic [DATA_W-1:0]                 ex_data,
  output logic                              ex_ready,
  input  logic                              ld_valid,
  input  logic [ADDR_W-1:0]                 ld_rd,
  input  logic [DATA_W-1:0]                 ld_data,
  output logic [ADDR_W-1:0]                 write1,
  output logic [DATA_W-1:0]                 write_data,
  output logic                              regwrite,
  output logic [$clog2(LQ_DEPTH+1)-1:0]     ld_count,
  output logic                              overflow
);

  localparam int unsigned CntW  = $clog2(LQ_DEPTH + 1);
  localparam int unsigned PtrW  = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  logic [ADDR_W-1:0] lq_rd_q   [LQ_DEPTH];
  logic [DATA_W-1:0] lq_data_q [LQ_DEPTH];

  logic [PtrW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] write1_q, write1_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              overflow_q, overflow_d;

  logic lq_empty, lq_full, force_ex, pop, push, drop, ex_hs;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(LQ_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Grant decision uses only registered state, so ex_ready never depends on ex_valid.
  always_comb begin
    lq_empty = (count_q == '0);
    lq_full  = (count_q == CntW'(LQ_DEPTH));
    force_ex = (wait_q == WaitW'(MAX_WAIT));
    ex_ready = !reset && (lq_empty || force_ex);
    pop      = !lq_empty && !force_ex;
    ex_hs    = ex_valid && ex_ready;
    push     = ld_valid && (!lq_full || pop);
    drop     = ld_valid && lq_full && !pop;
  end

  always_comb begin
    head_d       = pop  ? ptr_inc(head_q) : head_q;
    tail_d       = push ? ptr_inc(tail_q) : tail_q;
    count_d      = count_q;
    overflow_d   = overflow_q || drop;
    wait_d       = '0;
    regwrite_d   = 1'b0;
    write1_d     = write1_q;
    write_data_d = write_data_q;

    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    if (ex_valid && !ex_ready) begin
      wait_d = force_ex ? wait_q : wait_q + WaitW'(1);
    end

    // Writes to x0 are consumed but never reach the register file.
    if (pop) begin
      if (lq_rd_q[head_q] != '0) begin
        regwrite_d   = 1'b1;
        write1_d     = lq_rd_q[head_q];
        write_data_d = lq_data_q[head_q];
      end
    end else if (ex_hs) begin
      if (ex_rd != '0) begin
        regwrite_d   = 1'b1;
        write1_d     = ex_rd;
        write_data_d = ex_data;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      wait_q       <= '0;
      regwrite_q   <= 1'b0;
      write1_q     <= '0;
      write_data_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      wait_q       <= wait_d;
      regwrite_q   <= regwrite_d;
      write1_q     <= write1_d;
      write_data_q <= write_data_d;
      overflow_q   <= overflow_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !reset) begin
      lq_rd_q[tail_q]   <= ld_rd;
      lq_data_q[tail_q] <= ld_data;
    end
  end

  assign regwrite   = regwrite_q;
  assign write1     = write1_q;
  assign write_data = write_data_q;
  assign ld_count   = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: each row drives one cycle of inputs, checks ex_ready in that
// cycle and the registered write port / FIFO status after the following rising edge.
module tb_rf_wb_arbiter;

  logic        CLK = 1'b0;
  logic        reset;
  logic        ex_valid, ld_valid, ex_ready, regwrite, overflow;
  logic [4:0]  ex_rd, ld_rd, write1;
  logic [31:0] ex_data, ld_data, write_data;
  logic [1:0]  ld_count;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 CLK = ~CLK;

  rf_wb_arbiter #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .LQ_DEPTH (2),
    .MAX_WAIT (3)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .ex_valid   (ex_valid),
    .ex_rd      (ex_rd),
    .ex_data    (ex_data),
    .ex_ready   (ex_ready),
    .ld_valid   (ld_valid),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .write1     (write1),
    .write_data (write_data),
    .regwrite   (regwrite),
    .ld_count   (ld_count),
    .overflow   (overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Inputs are applied just after a rising edge; results are sampled 1ns later.
  task automatic run_row(input string tag,
                         input logic ldv, input logic [4:0] lrd, input logic [31:0] ldat,
                         input logic exv, input logic [4:0] erd, input logic [31:0] edat,
                         input logic rdy, input logic rw, input logic [4:0] w1,
                         input logic [31:0] wd, input logic [1:0] cnt, input logic ovf);
    ld_valid = ldv; ld_rd = lrd; ld_data = ldat;
    ex_valid = exv; ex_rd = erd; ex_data = edat;
    #1;
    check_eq({tag, ".ex_ready"}, ex_ready, rdy);
    @(posedge CLK);
    #1;
    check_eq({tag, ".regwrite"}, regwrite, rw);
    check_eq({tag, ".write1"}, write1, w1);
    check_eq({tag, ".write_data"}, write_data, wd);
    check_eq({tag, ".ld_count"}, ld_count, cnt);
    check_eq({tag, ".overflow"}, overflow, ovf);
  endtask

  initial begin
    reset = 1'b1;
    ex_valid = 1'b0; ex_rd = '0; ex_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    repeat (2) @(posedge CLK);
    #1;
    check_eq("rst.ex_ready", ex_ready, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++)
      run_row("idle", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    run_row("ex5", 0, 0, 0, 1, 5, 32'hDEADBEEF, 1, 1, 5, 32'hDEADBEEF, 0, 0);

    // Load priority: queued load beats a waiting execute request.
    run_row("ldp0", 1, 7, 32'h11, 0, 0, 0, 1, 0, 5, 32'hDEADBEEF, 1, 0);
    run_row("ldp1", 0, 0, 0, 1, 3, 32'h22, 0, 1, 7, 32'h11, 0, 0);
    run_row("ldp2", 0, 0, 0, 1, 3, 32'h22, 1, 1, 3, 32'h22, 0, 0);

    run_row("x0", 0, 0, 0, 1, 0, 32'hFFFF, 1, 0, 3, 32'h22, 0, 0);

    // Starvation bound, full-with-pop acceptance, then a dropped return on a forced cycle.
    run_row("stA", 1, 1, 32'h101, 0, 0, 0, 1, 0, 3, 32'h22, 1, 0);
    run_row("st1", 1, 2, 32'h102, 1, 9, 32'h99, 0, 1, 1, 32'h101, 1, 0);
    run_row("st2", 1, 3, 32'h103, 1, 9, 32'h99, 0, 1, 2, 32'h102, 1, 0);
    run_row("st3", 1, 4, 32'h104, 1, 9, 32'h99, 0, 1, 3, 32'h103, 1, 0);
    run_row("st4", 1, 5, 32'h105, 1, 9, 32'h99, 1, 1, 9, 32'h99, 2, 0);
    run_row("st5", 1, 6, 32'h106, 1, 10, 32'hAA, 0, 1, 4, 32'h104, 2, 0);
    run_row("st6", 1, 7, 32'h107, 1, 10, 32'hAA, 0, 1, 5, 32'h105, 2, 0);
    run_row("st7", 1, 8, 32'h108, 1, 10, 32'hAA, 0, 1, 6, 32'h106, 2, 0);
    run_row("st8", 1, 9, 32'h109, 1, 10, 32'hAA, 1, 1, 10, 32'hAA, 2, 1);

    // Reset with two queued entries; the load strobed during reset is discarded.
    reset = 1'b1;
    run_row("rstq", 1, 20, 32'h120, 1, 11, 32'hBB, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++)
      run_row("post", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
